return_addr_stack: RTL and testbench

- Hardware return-address stack directly downstream of the control unit.
- Consumes the JAL/JS decode: PC_Store (JAL push) and Jump[1] (JS pop), qualified by pc_load.
- Holds return addresses for the fetch stage; on JS, the fetch stage takes the next PC from top_addr instead of a register-file read.
- Circular LIFO with sticky overflow/underflow flags.

---
 rtl/cpu_pkg.sv | 15 +
 rtl/return_addr_stack.sv | 98 +++++++++
 tb/tb_return_addr_stack.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared control-encoding constants for the CPU core and its return-address stack.
// Constants only; no timing or flow-control behaviour.
package cpu_pkg;

  localparam logic [1:0] JUMP_NONE = 2'b00;
  localparam logic [1:0] JUMP_J    = 2'b01;
  localparam logic [1:0] JUMP_JS   = 2'b10;

  localparam logic [1:0] MEMTOREG_ALU = 2'b00;
  localparam logic [1:0] MEMTOREG_MEM = 2'b01;
  localparam logic [1:0] MEMTOREG_JAL = 2'b10;

  localparam int RAS_DEPTH = 16;

endpackage

// File: rtl/return_addr_stack.sv
// Circular return-address LIFO fed by JAL push / JS pop with sticky overflow/underflow flags.
// Single-cycle update, top_addr combinational; always ready, no backpressure (en=0 stalls).
module return_addr_stack
  import cpu_pkg::*;
#(
  parameter  int DEPTH = RAS_DEPTH,
  parameter  int AW    = 32,
  localparam int CW    = $clog2(DEPTH) + 1
) (
  input  logic          Clock,
  input  logic          Reset,
  input  logic          en,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] push_addr,
  input  logic          clr_err,
  output logic [AW-1:0] top_addr,
  output logic [CW-1:0] count,
  output logic          empty,
  output logic          full,
  output logic          overflow,
  output logic          underflow
);

  localparam int PW = $clog2(DEPTH);

  logic [AW-1:0] mem [DEPTH];
  logic [PW-1:0] tp, tp_nxt, wr_idx;
  logic [CW-1:0] cnt_nxt;
  logic          ovf_nxt, unf_nxt, wr_en;

  assign empty    = (count == '0);
  assign full     = (count == CW'(DEPTH));
  assign top_addr = empty ? '0 : mem[tp];

  always_comb begin
    tp_nxt  = tp;
    cnt_nxt = count;
    ovf_nxt = overflow;
    unf_nxt = underflow;
    wr_en   = 1'b0;
    wr_idx  = tp;
    if (en) begin
      // Clear first so a flag condition in the same cycle overrides it.
      if (clr_err) begin
        ovf_nxt = 1'b0;
        unf_nxt = 1'b0;
      end
      unique case ({push, pop})
        2'b10: begin
          tp_nxt = tp + PW'(1);
          wr_en  = 1'b1;
          wr_idx = tp + PW'(1);
          if (full) ovf_nxt = 1'b1;
          else      cnt_nxt = count + CW'(1);
        end
        2'b01: begin
          if (empty) begin
            unf_nxt = 1'b1;
          end else begin
            tp_nxt  = tp - PW'(1);
            cnt_nxt = count - CW'(1);
          end
        end
        2'b11: begin
          wr_en = 1'b1;
          if (empty) begin
            // Nothing to replace: flag the pop, then perform the push.
            unf_nxt = 1'b1;
            tp_nxt  = tp + PW'(1);
            wr_idx  = tp + PW'(1);
            cnt_nxt = CW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      tp        <= PW'(DEPTH - 1);
      count     <= '0;
      overflow  <= 1'b0;
      underflow <= 1'b0;
    end else begin
      tp        <= tp_nxt;
      count     <= cnt_nxt;
      overflow  <= ovf_nxt;
      underflow <= unf_nxt;
    end
  end

  always_ff @(posedge Clock) begin
    if (wr_en) mem[wr_idx] <= push_addr;
  end

endmodule

// File: tb/tb_return_addr_stack.sv
// Bench for return_addr_stack (DEPTH=4): directed scenarios with literal checks, then random
// traffic, all compared every cycle against a queue-based model of the stack.
module tb_return_addr_stack;

  localparam int DEPTH = 4;
  localparam int AW    = 32;
  localparam int CW    = $clog2(DEPTH) + 1;

  logic          Clock, Reset;
  logic          en, push, pop, clr_err;
  logic [AW-1:0] push_addr;
  logic [AW-1:0] top_addr;
  logic [CW-1:0] count;
  logic          empty, full, overflow, underflow;

  return_addr_stack #(.DEPTH(DEPTH), .AW(AW)) dut (
    .Clock(Clock), .Reset(Reset), .en(en), .push(push), .pop(pop),
    .push_addr(push_addr), .clr_err(clr_err), .top_addr(top_addr),
    .count(count), .empty(empty), .full(full),
    .overflow(overflow), .underflow(underflow)
  );

  int checks = 0;
  int errors = 0;

  // Model: back of the queue is the top of stack.
  logic [AW-1:0] m_q[$];
  bit            m_ovf, m_unf;
  bit            cmp_en = 0;

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] m_top();
    return (m_q.size() == 0) ? '0 : m_q[m_q.size()-1];
  endfunction

  function automatic void model_op(input bit e, input bit p, input bit o,
                                   input logic [AW-1:0] a, input bit c);
    if (!e) return;
    if (c) begin
      m_ovf = 0;
      m_unf = 0;
    end
    if (p && !o) begin
      if (m_q.size() == DEPTH) begin
        void'(m_q.pop_front());
        m_ovf = 1;
      end
      m_q.push_back(a);
    end else if (o && !p) begin
      if (m_q.size() == 0) m_unf = 1;
      else void'(m_q.pop_back());
    end else if (p && o) begin
      if (m_q.size() == 0) begin
        m_unf = 1;
        m_q.push_back(a);
      end else begin
        m_q[m_q.size()-1] = a;
      end
    end
  endfunction

  task automatic step(input bit e, input bit p, input bit o,
                      input logic [AW-1:0] a, input bit c);
    en = e; push = p; pop = o; push_addr = a; clr_err = c;
    @(posedge Clock);
    #1;
    model_op(e, p, o, a, c);
    en = 0; push = 0; pop = 0; clr_err = 0;
  endtask

  always @(negedge Clock) begin
    if (cmp_en) begin
      chk("count",     64'(count),     64'(m_q.size()));
      chk("top_addr",  64'(top_addr),  64'(m_top()));
      chk("empty",     64'(empty),     64'(m_q.size() == 0));
      chk("full",      64'(full),      64'(m_q.size() == DEPTH));
      chk("overflow",  64'(overflow),  64'(m_ovf));
      chk("underflow", 64'(underflow), 64'(m_unf));
    end
  end

  initial begin
    Reset = 1'b1; en = 0; push = 0; pop = 0; clr_err = 0; push_addr = '0;
    #12 Reset = 1'b0;
    chk("rst_count", 64'(count), 0);
    chk("rst_empty", 64'(empty), 1);
    chk("rst_full", 64'(full), 0);
    chk("rst_top", 64'(top_addr), 0);
    chk("rst_flags", 64'({overflow, underflow}), 0);
    cmp_en = 1;
    step(0, 0, 0, 0, 0);

    // Fill, then drain.
    step(1, 1, 0, 32'h10, 0);
    chk("push1_top", 64'(top_addr), 64'h10);
    step(1, 1, 0, 32'h20, 0);
    step(1, 1, 0, 32'h30, 0);
    step(1, 1, 0, 32'h40, 0);
    chk("push4_count", 64'(count), 4);
    chk("push4_full", 64'(full), 1);
    chk("push4_top", 64'(top_addr), 64'h40);
    step(1, 0, 1, 0, 0); chk("pop1_top", 64'(top_addr), 64'h30);
    step(1, 0, 1, 0, 0); chk("pop2_top", 64'(top_addr), 64'h20);
    step(1, 0, 1, 0, 0); chk("pop3_top", 64'(top_addr), 64'h10);
    step(1, 0, 1, 0, 0); chk("pop4_top", 64'(top_addr), 0);
    chk("pop4_empty", 64'(empty), 1);

    // Overflow wraps over the oldest entry.
    for (int i = 1; i <= 4; i++) step(1, 1, 0, 32'(i * 16), 0);
    step(1, 1, 0, 32'h50, 0);
    chk("ovf_count", 64'(count), 4);
    chk("ovf_flag", 64'(overflow), 1);
    chk("ovf_top", 64'(top_addr), 64'h50);
    step(1, 0, 1, 0, 0); chk("ovf_pop1", 64'(top_addr), 64'h40);
    step(1, 0, 1, 0, 0); chk("ovf_pop2", 64'(top_addr), 64'h30);
    step(1, 0, 1, 0, 0); chk("ovf_pop3", 64'(top_addr), 64'h20);
    step(1, 0, 1, 0, 0); chk("ovf_pop4_empty", 64'(empty), 1);

    // Underflow and clear priority.
    step(1, 0, 0, 0, 1);
    step(1, 0, 1, 0, 0);
    chk("unf_count", 64'(count), 0);
    chk("unf_flag", 64'(underflow), 1);
    step(1, 0, 0, 0, 1);
    chk("unf_clr", 64'(underflow), 0);
    step(1, 0, 1, 0, 1);
    chk("unf_clr_vs_set", 64'(underflow), 1);

    // Replace top.
    step(1, 0, 0, 0, 1);
    step(1, 1, 0, 32'h10, 0);
    step(1, 1, 0, 32'h20, 0);
    step(1, 1, 1, 32'h99, 0);
    chk("rep_count", 64'(count), 2);
    chk("rep_top", 64'(top_addr), 64'h99);
    step(1, 0, 1, 0, 0);
    chk("rep_pop", 64'(top_addr), 64'h10);
    step(1, 0, 1, 0, 0);
    step(1, 1, 1, 32'h99, 0);
    chk("rep_empty_count", 64'(count), 1);
    chk("rep_empty_top", 64'(top_addr), 64'h99);
    chk("rep_empty_unf", 64'(underflow), 1);

    // Stall, then asynchronous reset between edges.
    step(0, 1, 0, 32'h77, 1);
    chk("stall_count", 64'(count), 1);
    chk("stall_top", 64'(top_addr), 64'h99);
    chk("stall_unf", 64'(underflow), 1);
    step(1, 1, 0, 32'hA1, 0);
    step(1, 1, 0, 32'hA2, 0);
    chk("pre_rst_count", 64'(count), 3);
    #1 Reset = 1'b1;
    #1;
    chk("async_rst_count", 64'(count), 0);
    chk("async_rst_top", 64'(top_addr), 0);
    chk("async_rst_unf", 64'(underflow), 0);
    m_q.delete(); m_ovf = 0; m_unf = 0;
    #1 Reset = 1'b0;

    // Random traffic.
    for (int n = 0; n < 3000; n++) begin
      step(($urandom % 8) != 0, $urandom % 2 == 1, $urandom % 2 == 1,
           $urandom, ($urandom % 8) == 0);
    end

    step(0, 0, 0, 0, 0);
    cmp_en = 0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
